// File: rtl/stream_pkg.sv
// Shared types for the 1:2 packet demultiplexer: default widths, FSM encoding
// and the {last, data} beat stored in each output buffer.
package stream_pkg;

  localparam int DATA_W = 16;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROUTE1 = 2'd1,
    ROUTE2 = 2'd2
  } state_t;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } beat_t;

endpackage

// File: rtl/stream_demux_1_2_16bit_if.sv
// Input stream plus both output streams of the demux; slave is the demux side,
// master is the side that sources input beats and consumes both outputs.
interface stream_demux_1_2_16bit_if #(
  parameter int DATA_W = stream_pkg::DATA_W
);

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_last;
  logic              in_sel;
  logic              in_ready;

  logic [DATA_W-1:0] o1_data;
  logic              o1_valid;
  logic              o1_last;
  logic              o1_ready;

  logic [DATA_W-1:0] o2_data;
  logic              o2_valid;
  logic              o2_last;
  logic              o2_ready;

  modport slave (
    input  in_data, in_valid, in_last, in_sel, o1_ready, o2_ready,
    output in_ready, o1_data, o1_valid, o1_last, o2_data, o2_valid, o2_last
  );

  modport master (
    output in_data, in_valid, in_last, in_sel, o1_ready, o2_ready,
    input  in_ready, o1_data, o1_valid, o1_last, o2_data, o2_valid, o2_last
  );

endinterface

// File: rtl/fifo2_16bit.sv
// Two-entry synchronous FIFO of {last, data} beats; the head entry drives the
// read outputs directly, so a beat written at edge N is readable after edge N.
module fifo2_16bit
  import stream_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_last,
  output logic              full,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              empty
);

  beat_t       mem [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;
  logic        wr;
  logic        rd;

  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);
  assign wr    = wr_en && !full;
  assign rd    = rd_en && !empty;

  // NOTE: the two storage entries are reset because the head entry is the
  // visible output data, which must read as zero straight out of reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (wr) begin
        mem[wr_ptr] <= '{last: wr_last, data: wr_data};
        wr_ptr      <= !wr_ptr;
      end
      if (rd) rd_ptr <= !rd_ptr;
      if (wr && !rd)      count <= count + 2'd1;
      else if (rd && !wr) count <= count - 2'd1;
    end
  end

  assign rd_data = mem[rd_ptr].data;
  assign rd_last = mem[rd_ptr].last;

endmodule

// File: rtl/stream_demux_1_2_16bit.sv
// Packet-level 1:2 stream demux: the destination is taken from in_sel on a
// packet's first beat and held until its last beat; each output has a 2-entry FIFO.
module stream_demux_1_2_16bit #(
  parameter int DATA_W = stream_pkg::DATA_W,
  parameter int CNT_W  = stream_pkg::CNT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  stream_demux_1_2_16bit_if.slave bus,
  output logic [CNT_W-1:0]        pkt_cnt1,
  output logic [CNT_W-1:0]        pkt_cnt2,
  output logic                    busy
);

  import stream_pkg::*;

  state_t state;
  state_t state_n;
  logic   tgt;
  logic   in_ready;
  logic   accept;
  logic   full1, full2;
  logic   empty1, empty2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned and infers a latch.
  always_comb begin
    state_n = state;
    case (state)
      ROUTE1:  tgt = 1'b0;
      ROUTE2:  tgt = 1'b1;
      default: tgt = bus.in_sel;
    endcase
    // Only the FIFO of the locked (or about-to-be-locked) destination can stall input.
    in_ready = !rst && !(tgt ? full2 : full1);
    accept   = bus.in_valid && in_ready;
    if (accept) begin
      if (bus.in_last) state_n = IDLE;
      else             state_n = tgt ? ROUTE2 : ROUTE1;
    end
  end

  assign bus.in_ready = in_ready;
  assign busy         = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt1 <= '0;
      pkt_cnt2 <= '0;
    end else if (accept && bus.in_last) begin
      if (tgt) pkt_cnt2 <= pkt_cnt2 + 1'b1;
      else     pkt_cnt1 <= pkt_cnt1 + 1'b1;
    end
  end

  fifo2_16bit u_fifo1 (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (accept && !tgt),
    .wr_data (bus.in_data),
    .wr_last (bus.in_last),
    .full    (full1),
    .rd_en   (bus.o1_ready),
    .rd_data (bus.o1_data),
    .rd_last (bus.o1_last),
    .empty   (empty1)
  );

  fifo2_16bit u_fifo2 (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (accept && tgt),
    .wr_data (bus.in_data),
    .wr_last (bus.in_last),
    .full    (full2),
    .rd_en   (bus.o2_ready),
    .rd_data (bus.o2_data),
    .rd_last (bus.o2_last),
    .empty   (empty2)
  );

  assign bus.o1_valid = !empty1;
  assign bus.o2_valid = !empty2;

endmodule

// File: tb/tb_stream_demux_1_2_16bit.sv
// Self-checking bench for stream_demux_1_2_16bit: a directed vector table for
// streaming cases plus hand-written back-pressure, async-reset and wrap sequences.
module tb_stream_demux_1_2_16bit;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] pkt_cnt1;
  logic [7:0] pkt_cnt2;
  logic       busy;

  int total = 0;
  int bad   = 0;

  stream_demux_1_2_16bit_if #(.DATA_W(16)) bus ();

  stream_demux_1_2_16bit #(.DATA_W(16), .CNT_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .pkt_cnt1 (pkt_cnt1),
    .pkt_cnt2 (pkt_cnt2),
    .busy     (busy)
  );

  always #5 clk = !clk;

  // Beats handed over on each output, as {last, data}.
  logic [16:0] q1 [$];
  logic [16:0] q2 [$];

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.o1_valid && bus.o1_ready) q1.push_back({bus.o1_last, bus.o1_data});
      if (bus.o2_valid && bus.o2_ready) q2.push_back({bus.o2_last, bus.o2_data});
    end
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Present one beat and wait (bounded) until it is accepted; ends at posedge+1.
  task automatic send(input logic [15:0] data, input logic last, input logic sel);
    bit done = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = data;
    bus.in_last  = last;
    bus.in_sel   = sel;
    for (int c = 0; c < 50 && !done; c++) begin
      #1;
      done = bus.in_ready;
      @(posedge clk);
      #1;
    end
    if (!done) check("send_timeout", 32'(data), 32'hFFFF_FFFF);
    bus.in_valid = 1'b0;
  endtask

  typedef struct {
    logic        vld;
    logic        sel;
    logic        last;
    logic [15:0] data;
    logic        e_rdy;
    logic        e1v;
    logic [15:0] e1d;
    logic        e1l;
    logic        e2v;
    logic [15:0] e2d;
    logic        e2l;
    logic        ebusy;
  } vec_t;

  function automatic vec_t mk(input logic vld, input logic sel, input logic last,
                              input logic [15:0] data, input logic e_rdy,
                              input logic e1v, input logic [15:0] e1d, input logic e1l,
                              input logic e2v, input logic [15:0] e2d, input logic e2l,
                              input logic ebusy);
    vec_t v;
    v.vld = vld; v.sel = sel; v.last = last; v.data = data; v.e_rdy = e_rdy;
    v.e1v = e1v; v.e1d = e1d; v.e1l = e1l;
    v.e2v = e2v; v.e2d = e2d; v.e2l = e2l; v.ebusy = ebusy;
    return v;
  endfunction

  vec_t vecs [14];

  initial begin
    // Streaming vectors, both consumers ready; expectations are after the edge.
    vecs[0]  = mk(1, 0, 0, 16'h0001, 1, 1, 16'h0001, 0, 0, 16'h0, 0, 1);
    vecs[1]  = mk(1, 0, 0, 16'h0002, 1, 1, 16'h0002, 0, 0, 16'h0, 0, 1);
    vecs[2]  = mk(1, 0, 0, 16'h0003, 1, 1, 16'h0003, 0, 0, 16'h0, 0, 1);
    vecs[3]  = mk(1, 0, 1, 16'h0004, 1, 1, 16'h0004, 1, 0, 16'h0, 0, 0);
    vecs[4]  = mk(0, 0, 0, 16'h0000, 1, 0, 16'h0,    0, 0, 16'h0, 0, 0);
    vecs[5]  = mk(1, 1, 0, 16'h0011, 1, 0, 16'h0,    0, 1, 16'h0011, 0, 1);
    vecs[6]  = mk(1, 0, 0, 16'h0012, 1, 0, 16'h0,    0, 1, 16'h0012, 0, 1);
    vecs[7]  = mk(1, 0, 1, 16'h0013, 1, 0, 16'h0,    0, 1, 16'h0013, 1, 0);
    vecs[8]  = mk(0, 0, 0, 16'h0000, 1, 0, 16'h0,    0, 0, 16'h0, 0, 0);
    vecs[9]  = mk(1, 0, 1, 16'h0021, 1, 1, 16'h0021, 1, 0, 16'h0, 0, 0);
    vecs[10] = mk(1, 1, 1, 16'h0022, 1, 0, 16'h0,    0, 1, 16'h0022, 1, 0);
    vecs[11] = mk(1, 0, 1, 16'h0023, 1, 1, 16'h0023, 1, 0, 16'h0, 0, 0);
    vecs[12] = mk(1, 1, 1, 16'h0024, 1, 0, 16'h0,    0, 1, 16'h0024, 1, 0);
    vecs[13] = mk(0, 0, 0, 16'h0000, 1, 0, 16'h0,    0, 0, 16'h0, 0, 0);

    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    bus.in_sel   = 1'b0;
    bus.o1_ready = 1'b1;
    bus.o2_ready = 1'b1;

    // Reset then idle
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 0);
    check("rst_o1_valid", 32'(bus.o1_valid), 0);
    check("rst_o2_valid", 32'(bus.o2_valid), 0);
    check("rst_o1_data",  32'(bus.o1_data), 0);
    check("rst_o2_data",  32'(bus.o2_data), 0);
    check("rst_o1_last",  32'(bus.o1_last), 0);
    check("rst_busy",     32'(busy), 0);
    rst = 1'b0;
    #1;
    check("idle_in_ready", 32'(bus.in_ready), 1);
    check("idle_cnt1", 32'(pkt_cnt1), 0);
    check("idle_cnt2", 32'(pkt_cnt2), 0);
    @(posedge clk);
    #1;

    // Vector table: 4-beat to out1, locked select to out2, alternating singles
    for (int i = 0; i < 14; i++) begin
      bus.in_valid = vecs[i].vld;
      bus.in_sel   = vecs[i].sel;
      bus.in_last  = vecs[i].last;
      bus.in_data  = vecs[i].data;
      #1;
      check($sformatf("v%0d_in_ready", i), 32'(bus.in_ready), 32'(vecs[i].e_rdy));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_o1_valid", i), 32'(bus.o1_valid), 32'(vecs[i].e1v));
      if (vecs[i].e1v) begin
        check($sformatf("v%0d_o1_data", i), 32'(bus.o1_data), 32'(vecs[i].e1d));
        check($sformatf("v%0d_o1_last", i), 32'(bus.o1_last), 32'(vecs[i].e1l));
      end
      check($sformatf("v%0d_o2_valid", i), 32'(bus.o2_valid), 32'(vecs[i].e2v));
      if (vecs[i].e2v) begin
        check($sformatf("v%0d_o2_data", i), 32'(bus.o2_data), 32'(vecs[i].e2d));
        check($sformatf("v%0d_o2_last", i), 32'(bus.o2_last), 32'(vecs[i].e2l));
      end
      check($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].ebusy));
    end
    bus.in_valid = 1'b0;
    check("tbl_cnt1", 32'(pkt_cnt1), 3);
    check("tbl_cnt2", 32'(pkt_cnt2), 3);

    // Back-pressure on out1 with an out2-selecting beat waiting behind it
    q1.delete();
    q2.delete();
    bus.o1_ready = 1'b0;
    send(16'h0031, 1'b0, 1'b0);
    send(16'h0032, 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h0033;
    bus.in_last  = 1'b0;
    bus.in_sel   = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("bp_in_ready", 32'(bus.in_ready), 0);
      check("bp_o1_hold",  32'(bus.o1_data), 32'h0031);
      check("bp_o1_valid", 32'(bus.o1_valid), 1);
      check("bp_o2_valid", 32'(bus.o2_valid), 0);
      check("bp_busy",     32'(busy), 1);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    bus.o1_ready = 1'b1;
    send(16'h0033, 1'b0, 1'b1);
    send(16'h0034, 1'b0, 1'b1);
    send(16'h0035, 1'b1, 1'b1);
    send(16'h0041, 1'b1, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("bp_q1_size", 32'(q1.size()), 5);
    for (int i = 0; i < 5; i++) begin
      logic [16:0] got;
      logic [16:0] exp;
      got = (i < q1.size()) ? q1[i] : 17'h1FFFF;
      exp = {(i == 4), 16'(16'h0031 + i)};
      check($sformatf("bp_q1_beat%0d", i), 32'(got), 32'(exp));
    end
    check("bp_q2_size", 32'(q2.size()), 1);
    check("bp_q2_beat", 32'((q2.size() > 0) ? q2[0] : 17'h1FFFF), 32'h1_0041);

    // Async reset mid-packet, with no clock edge between assert and check
    q1.delete();
    q2.delete();
    bus.o1_ready = 1'b0;
    send(16'h0061, 1'b0, 1'b0);
    send(16'h0062, 1'b0, 1'b0);
    check("ar_pre_o1_valid", 32'(bus.o1_valid), 1);
    #3;
    rst = 1'b1;
    #1;
    check("ar_o1_valid", 32'(bus.o1_valid), 0);
    check("ar_o1_data",  32'(bus.o1_data), 0);
    check("ar_busy",     32'(busy), 0);
    check("ar_in_ready", 32'(bus.in_ready), 0);
    check("ar_cnt1",     32'(pkt_cnt1), 0);
    check("ar_cnt2",     32'(pkt_cnt2), 0);
    #2;
    rst = 1'b0;
    bus.o1_ready = 1'b1;
    @(posedge clk);
    #1;
    send(16'h0051, 1'b1, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check("ar_q1_size", 32'(q1.size()), 0);
    check("ar_q2_size", 32'(q2.size()), 1);
    check("ar_q2_beat", 32'((q2.size() > 0) ? q2[0] : 17'h1FFFF), 32'h1_0051);
    check("ar_post_cnt2", 32'(pkt_cnt2), 1);

    // 256 back-to-back single-beat packets to out1: counter wraps to zero
    bus.in_valid = 1'b1;
    bus.in_sel   = 1'b0;
    bus.in_last  = 1'b1;
    for (int i = 0; i < 256; i++) begin
      bus.in_data = 16'(i);
      @(posedge clk);
      #1;
      if (i == 254) check("wrap_cnt1_255", 32'(pkt_cnt1), 255);
    end
    bus.in_valid = 1'b0;
    check("wrap_cnt1_0", 32'(pkt_cnt1), 0);
    check("wrap_cnt2",   32'(pkt_cnt2), 1);
    check("wrap_busy",   32'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
